// File: rtl/load_store_unit.sv
// load_store_unit
// Memory stage of the pipeline. It takes the decoder's byte-lane masks, the
// effective address and the store data, then runs one data-memory transaction
// over a req/ack bus. Loads are extracted from the returned word and
// sign- or zero-extended. Illegal masks and misaligned addresses fault without
// touching the bus. The pipeline is stalled until the access completes.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   op_valid          memory instruction present (held while stall_o is high)
//   mem_read/write    lane masks: 0001 byte, 0011 half, 1111 word, 0000 none
//   funct3            bit 2 selects an unsigned load (LBU/LHU)
//   addr, wdata       effective address and store data
//   stall_o           freeze upstream stages
//   done, misaligned  one-cycle completion / fault pulses
//   load_data         extended load result, valid with done
//   dmem_*            registered data-memory bus; dmem_ack/dmem_rdata return
//
// state | meaning
// IDLE  | waiting for an access; inputs are sampled only here
// REQ   | bus request outstanding, outputs held until dmem_ack
// RESP  | access finished, done pulse with load_data
// FAULT | illegal mask or misaligned address, done + misaligned pulse

module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [3:0]      mem_read,
  input  logic [3:0]      mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall_o,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e          state_q;
  logic [3:0]      mask_q;
  logic [1:0]      off_q;
  logic            uns_q;
  logic            done_q;
  logic            misaligned_q;
  logic [XLEN-1:0] load_data_q;
  logic            req_q;
  logic            we_q;
  logic [XLEN-1:0] dmem_addr_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] dmem_wdata_q;

  logic            access;
  logic [3:0]      mask_d;
  logic            fault_d;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data_d;
  logic            unused_funct3;

  assign unused_funct3 = ^funct3[1:0];

  assign access = op_valid && ((mem_read != 4'b0000) || (mem_write != 4'b0000));
  assign mask_d = mem_read | mem_write;

  // Both masks set, or any pattern other than byte/half/word, is a fault.
  always_comb begin
    fault_d = 1'b0;
    if ((mem_read != 4'b0000) && (mem_write != 4'b0000)) begin
      fault_d = 1'b1;
    end else begin
      case (mask_d)
        4'b0001: fault_d = 1'b0;
        4'b0011: fault_d = addr[0];
        4'b1111: fault_d = (addr[1:0] != 2'b00);
        default: fault_d = 1'b1;
      endcase
    end
  end

  assign be_d = mask_d << addr[1:0];

  always_comb begin
    wdata_d = wdata;
    case (mask_d)
      4'b0001: wdata_d = {4{wdata[7:0]}};
      4'b0011: wdata_d = {2{wdata[15:0]}};
      default: wdata_d = wdata;
    endcase
  end

  // Extraction works on the live bus word so the result is ready on the
  // cycle after ack without an extra rdata register.
  assign shifted = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data_d = shifted;
    case (mask_q)
      4'b0001: load_data_d = uns_q ? {24'b0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      4'b0011: load_data_d = uns_q ? {16'b0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data_d = shifted;
    endcase
    if (we_q) begin
      load_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= 4'b0000;
      off_q        <= 2'b00;
      uns_q        <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      load_data_q  <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      dmem_addr_q  <= '0;
      be_q         <= 4'b0000;
      dmem_wdata_q <= '0;
    end else begin
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access) begin
            if (fault_d) begin
              state_q      <= FAULT;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
              load_data_q  <= '0;
            end else begin
              state_q      <= REQ;
              mask_q       <= mask_d;
              off_q        <= addr[1:0];
              uns_q        <= funct3[2];
              req_q        <= 1'b1;
              we_q         <= (mem_write != 4'b0000);
              dmem_addr_q  <= {addr[XLEN-1:2], 2'b00};
              be_q         <= be_d;
              dmem_wdata_q <= wdata_d;
            end
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state_q      <= RESP;
            done_q       <= 1'b1;
            load_data_q  <= load_data_d;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            dmem_addr_q  <= '0;
            be_q         <= 4'b0000;
            dmem_wdata_q <= '0;
          end
        end
        RESP:    state_q <= IDLE;
        FAULT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o    = ((state_q == IDLE) && access) || (state_q == REQ);
  assign done       = done_q;
  assign misaligned = misaligned_q;
  assign load_data  = load_data_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus randomized accesses
// checked against a byte-level reference model.

module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [3:0]  mem_read;
  logic [3:0]  mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall_o;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int vectors;
  int miscompares;

  load_store_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall_o    (stall_o),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete access: drive it, play the bus with `waits` extra ack
  // cycles, and compare each cycle against the reference model.
  task automatic run_op(input logic [3:0] rd, input logic [3:0] wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rword,
                        input int waits, input string tag);
    logic [3:0]  m;
    int          nb;
    int          off;
    logic        exp_fault;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_ld;
    longint      v;
    int          exp_lat;

    m   = rd | wr;
    off = int'(a[1:0]);
    nb  = (m == 4'b0001) ? 1 : (m == 4'b0011) ? 2 : 4;
    exp_fault = (rd != 0 && wr != 0) || !(m == 4'b0001 || m == 4'b0011 || m == 4'b1111)
                || (off % nb != 0);
    exp_be = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
    v = longint'(rword) >> (8 * off);
    v = v & ((64'd1 << (8 * nb)) - 1);
    if (!f3[2] && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1) v = v - (64'd1 << (8 * nb));
    exp_ld  = (wr != 0 || exp_fault) ? 32'h0 : v[31:0];
    exp_lat = exp_fault ? 1 : waits + 2;

    @(posedge clk); #1;
    op_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    dmem_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (stall_o !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s cycle0: stall_o=%b done=%b, required stall_o=1 done=0", tag, stall_o, done);
    end

    for (int cyc = 1; cyc <= exp_lat; cyc++) begin
      @(posedge clk); #1;
      dmem_ack   = (!exp_fault && cyc == waits + 1);
      dmem_rdata = dmem_ack ? rword : $urandom;
      addr  = $urandom;
      wdata = $urandom;
      funct3 = 3'($urandom);
      @(negedge clk);
      vectors++;
      if (cyc < exp_lat) begin
        if (dmem_req !== 1'b1 || stall_o !== 1'b1 || done !== 1'b0 ||
            dmem_addr !== {a[31:2], 2'b00} || dmem_be !== exp_be ||
            dmem_we !== (wr != 0) || (wr != 0 && dmem_wdata !== exp_wd)) begin
          miscompares++;
          $display("FAIL %s bus cycle%0d: req=%b stall=%b done=%b addr=%h be=%b we=%b wd=%h, required req=1 stall=1 done=0 addr=%h be=%b we=%b wd=%h",
                   tag, cyc, dmem_req, stall_o, done, dmem_addr, dmem_be, dmem_we, dmem_wdata,
                   {a[31:2], 2'b00}, exp_be, (wr != 0), exp_wd);
        end
      end else begin
        if (done !== 1'b1 || misaligned !== exp_fault || load_data !== exp_ld ||
            stall_o !== 1'b0 || dmem_req !== 1'b0) begin
          miscompares++;
          $display("FAIL %s done cycle%0d: done=%b mis=%b ld=%h stall=%b req=%b, required done=1 mis=%b ld=%h stall=0 req=0",
                   tag, cyc, done, misaligned, load_data, stall_o, dmem_req, exp_fault, exp_ld);
        end
      end
    end

    @(posedge clk); #1;
    op_valid = 1'b0; mem_read = 4'b0; mem_write = 4'b0; dmem_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || misaligned !== 1'b0 || dmem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after: done=%b mis=%b req=%b, required all 0", tag, done, misaligned, dmem_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; mem_read = 0; mem_write = 0; funct3 = 0;
    addr = 0; wdata = 0; dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({stall_o, done, misaligned, dmem_req, dmem_we} !== 5'b0 || dmem_be !== 4'b0 ||
        dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || load_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: stall=%b done=%b mis=%b req=%b we=%b be=%b addr=%h wd=%h ld=%h, required all 0",
               stall_o, done, misaligned, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(4'b1111, 4'b0000, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw_0x100");
    run_op(4'b0001, 4'b0000, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, "lb_0x103");
    run_op(4'b0001, 4'b0000, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, "lbu_0x103");
    run_op(4'b0000, 4'b0011, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 3, "sh_0x202");
    run_op(4'b1111, 4'b0000, 3'b010, 32'h102, 32'h0, 32'h0, 0, "lw_misaligned");
    run_op(4'b0011, 4'b0000, 3'b001, 32'h302, 32'h0, 32'h8001_7F00, 2, "lh_0x302");
    run_op(4'b0011, 4'b0011, 3'b001, 32'h300, 32'h0, 32'h0, 0, "both_masks");
  endtask

  task automatic test_no_access();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      op_valid = 1'b1; mem_read = 0; mem_write = 0; addr = $urandom; wdata = $urandom;
      @(negedge clk);
      vectors++;
      if (stall_o !== 1'b0 || done !== 1'b0 || dmem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL no_access%0d: stall=%b done=%b req=%b, required 0 0 0", i, stall_o, done, dmem_req);
      end
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    @(posedge clk); #1;
    op_valid = 1'b1; mem_read = 4'b1111; mem_write = 0; funct3 = 3'b010; addr = 32'h40;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (dmem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_req_pre: req=%b, required 1", dmem_req);
    end
    @(posedge clk); #1;
    rst = 1'b1; op_valid = 1'b0; mem_read = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (dmem_req !== 1'b0 || done !== 1'b0 || stall_o !== 1'b0 || dmem_be !== 4'b0) begin
      miscompares++;
      $display("FAIL rst_mid_req: req=%b done=%b stall=%b be=%b, required 0 0 0 0", dmem_req, done, stall_o, dmem_be);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_no_done%0d: done=%b, required 0", i, done);
      end
    end
    run_op(4'b1111, 4'b0000, 3'b010, 32'h0, 32'h0, 32'h1234_5678, 0, "lw_after_rst");
  endtask

  task automatic test_random();
    logic [3:0] rd;
    logic [3:0] wr;
    logic [3:0] pick;
    logic [31:0] a;
    int r;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 2))
        0: pick = 4'b0001;
        1: pick = 4'b0011;
        default: pick = 4'b1111;
      endcase
      rd = 0; wr = 0;
      r = $urandom_range(0, 9);
      if (r < 4) rd = pick;
      else if (r < 8) wr = pick;
      else if (r == 8) begin rd = pick; wr = 4'b0001; end
      else rd = 4'($urandom_range(1, 15));
      a = $urandom;
      if ($urandom_range(0, 9) < 6) a[1:0] = 2'b00;
      run_op(rd, wr, 3'($urandom), a, $urandom, $urandom, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_no_access();
    test_reset_mid_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
